spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_ctrl_pkg.sv | 14 +
 rtl/spi_master_ctrl_if.sv | 30 +++
 rtl/spi_clk_div.sv | 24 ++
 rtl/spi_master_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI master controller.
package spi_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        SHIFT     = 3'd2,
        WAIT_NEXT = 3'd3,
        HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command, receive and SPI pin bundle; master = the controller, slave = host plus SPI target.
interface spi_master_ctrl_if
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [DATA_W-1:0] cmd_data_i;
    logic              cmd_last_i;
    logic              rx_valid_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              busy_o;
    logic              spi_clk_o;
    logic              spi_mosi_o;
    logic              spi_cs_o;
    logic              spi_miso_i;

    modport master (
        input  cmd_valid_i, cmd_data_i, cmd_last_i, spi_miso_i,
        output cmd_ready_o, rx_valid_o, rx_data_o, busy_o,
               spi_clk_o, spi_mosi_o, spi_cs_o
    );

    modport slave (
        output cmd_valid_i, cmd_data_i, cmd_last_i, spi_miso_i,
        input  cmd_ready_o, rx_valid_o, rx_data_o, busy_o,
               spi_clk_o, spi_mosi_o, spi_cs_o
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles, restarts when disabled.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick_c
);
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: streams command words MSB first, holds CS across words until a last word.
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    spi_master_ctrl_if.master bus
);
    localparam int unsigned HALF_W = $clog2(2 * DATA_W);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
    logic [HALF_W-1:0] r_half_cnt, w_half_cnt_nxt;
    logic              r_last, w_last_nxt;
    logic              r_sclk, w_sclk_nxt;
    logic              r_mosi, w_mosi_nxt;
    logic              r_cs, w_cs_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_ready;
    logic              r_busy;
    logic              w_accept;
    logic              w_div_en;
    logic              w_tick_c;

    assign w_div_en = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_en     (w_div_en),
        .o_tick_c (w_tick_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_half_cnt <= '0;
            r_last     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_rx_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_half_cnt <= w_half_cnt_nxt;
            r_last     <= w_last_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs       <= w_cs_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_ready    <= (w_state_nxt == IDLE) || (w_state_nxt == WAIT_NEXT);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Rising SCLK samples MISO; falling SCLK advances MOSI, except the final one which closes the word.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_data_nxt  = r_rx_data;
        w_half_cnt_nxt = r_half_cnt;
        w_last_nxt     = r_last;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_nxt       = r_cs;
        w_rx_valid_nxt = 1'b0;
        w_accept       = bus.cmd_valid_i && r_ready;

        case (r_state)
            IDLE, WAIT_NEXT: begin
                if (w_accept) begin
                    w_tx_sh_nxt = bus.cmd_data_i;
                    w_last_nxt  = bus.cmd_last_i;
                    w_mosi_nxt  = bus.cmd_data_i[DATA_W-1];
                    w_cs_nxt    = 1'b0;
                    w_state_nxt = (r_state == IDLE) ? SETUP : SHIFT;
                end
            end
            SETUP: begin
                if (w_tick_c) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick_c) begin
                    w_sclk_nxt     = ~r_sclk;
                    w_half_cnt_nxt = (r_half_cnt == LAST_HALF) ? '0 : r_half_cnt + HALF_W'(1);
                    if (!r_sclk) begin
                        w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], bus.spi_miso_i};
                    end else if (r_half_cnt == LAST_HALF) begin
                        w_rx_valid_nxt = 1'b1;
                        w_rx_data_nxt  = r_rx_sh;
                        w_state_nxt    = r_last ? HOLD : WAIT_NEXT;
                    end else begin
                        w_tx_sh_nxt = r_tx_sh << 1;
                        w_mosi_nxt  = r_tx_sh[DATA_W-2];
                    end
                end
            end
            HOLD: begin
                if (w_tick_c) begin
                    w_cs_nxt    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready_o = r_ready;
    assign bus.rx_valid_o  = r_rx_valid;
    assign bus.rx_data_o   = r_rx_data;
    assign bus.busy_o      = r_busy;
    assign bus.spi_clk_o   = r_sclk;
    assign bus.spi_mosi_o  = r_mosi;
    assign bus.spi_cs_o    = r_cs;
endmodule
